// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a two-entry skid buffer, registered in_ready,
// NOP injection on flush and a configurable bubble instruction.
module if_id_skid #(
    parameter int unsigned         DATA_W    = 32,
    parameter int unsigned         PC_W      = 32,
    parameter logic [DATA_W-1:0]   NOP_INSTR = 'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc,
    input  logic              out_ready,
    input  logic              hold,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    // Handshake: an entry moves when valid and ready are both high at a rising
    // edge; valid never waits on ready, and in_ready is a flop so upstream
    // never sees a combinational path from out_ready or hold.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
    logic              acc;
    logic              cons;

    assign out_valid = (state_q != EMPTY);
    assign acc       = in_valid & in_ready_q;
    assign cons      = out_valid & out_ready & ~hold;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (flush) begin
            // out_pc keeps its last value so redirect debug still sees it
            state_d      = EMPTY;
            main_instr_d = NOP_INSTR;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_instr_d = in_instr;
                        main_pc_d    = in_pc;
                        state_d      = ONE;
                    end
                end
                ONE: begin
                    if (acc && cons) begin
                        main_instr_d = in_instr;
                        main_pc_d    = in_pc;
                    end else if (acc) begin
                        skid_instr_d = in_instr;
                        skid_pc_d    = in_pc;
                        state_d      = FULL;
                    end else if (cons) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (cons) begin
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                        state_d      = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b0;
            main_instr_q <= NOP_INSTR;
            main_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    // A consumed-out main register keeps stale data, so the bubble is muxed here
    assign out_instr = out_valid ? main_instr_q : NOP_INSTR;
    assign out_pc    = main_pc_q;
    assign in_ready  = in_ready_q;
    assign occupancy = state_q;

endmodule

// File: doc/if_id_skid.md
# if_id_skid

Parametrised IF/ID pipeline register with valid/ready handshaking and a two-entry skid buffer. It sits between instruction fetch and decode, carrying the instruction word and its PC. Compared with a plain hold/flush register, it adds three things: no-loss backpressure through a registered `in_ready`, NOP injection on flush, and a configurable bubble value. Width generalisation lets the same block serve RV32 and RV64 builds.

## Interface
- `DATA_W`, 32, instruction word width
- `PC_W`, 32, PC width
- `NOP_INSTR`, 32'h0000_0013, value driven on `out_instr` when the stage holds no valid entry (addi x0,x0,0); width DATA_W
- `clk`  in  1  clock; all state changes on its rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  fetch presents an instruction
- `in_instr`  in  DATA_W  fetched instruction
- `in_pc`  in  PC_W  PC of `in_instr`
- `in_ready`  out  1  stage accepts this cycle (registered)
- `out_valid`  out  1  decode-side entry valid
- `out_instr`  out  DATA_W  instruction to decode
- `out_pc`  out  PC_W  PC to decode
- `out_ready`  in  1  decode consumes this cycle
- `hold`  in  1  hazard-unit stall; equivalent to `out_ready`=0
- `flush`  in  1  branch/jump redirect; discard all entries
- `occupancy`  out  2  entries held (0..2)

## Operation
- Accept: `acc` = `in_valid` & `in_ready`.
- Consume: `cons` = `out_valid` & `out_ready` & ~`hold`.
- Storage consists of a main register (drives the `out_*` outputs) and a skid register. The skid register is filled only when an entry arrives while the main register is occupied and not consumed.
- States by occupancy:
  - EMPTY (0)
    - `acc` loads the main register → ONE.
  - ONE (1)
    - `acc` & `cons`: main register takes the input → ONE.
    - `acc` & ~`cons`: input goes to skid → FULL.
    - ~`acc` & `cons` → EMPTY.
  - FULL (2)
    - `cons`: skid moves to main → ONE.
    - `acc` is impossible because `in_ready`=0.
- `in_ready` next-state = (next occupancy < 2). It is a register, with no combinational path from `out_ready` or `hold`.
- Flush
  - Occupancy → 0 and `out_valid` → 0.
  - `out_instr` → NOP_INSTR.
  - `out_pc` retains its value.
  - `in_ready` → 1.
  - Flush overrides `acc` and `cons` in the same cycle. An input accepted in the flush cycle counts as transferred for upstream but is dropped.
- When `out_valid`=0, `out_instr` is NOP_INSTR.
- Ordering is strict FIFO. No entry is duplicated or lost except through flush.
- `occupancy` equals `out_valid` + skid-valid.

## Timing
- Reset values:
  - `out_valid`=0, `out_instr`=NOP_INSTR, `out_pc`=0, `occupancy`=0.
  - `in_ready`=0 while `rst_n`=0; it becomes 1 on the first edge with `rst_n`=1.
  - Skid register is cleared.
- Latency from input to output is 1 cycle when EMPTY, or ONE with `cons`.
- Throughput is 1 entry per cycle under continuous `out_ready`.
- When `cons` returns after backpressure, `in_ready` rises the cycle after `cons`, so the upstream sees a one-cycle recovery bubble.
- Reset asserted mid-operation discards all entries at the next edge, same as flush, except that `out_pc` → 0.
- `hold` and `flush` asserted together: flush wins.
- `hold`=1 with `out_ready`=1: no consumption.

## Test plan
- Reset release, then `in_valid`=1 for 4 cycles with PCs 0x0, 0x4, 0x8, 0xC and `out_ready`=1.
  - Expected: outputs appear one cycle later, in order, with `occupancy` ≤1 and `in_ready` held at 1.
- `hold`=1 for 3 cycles during a stream.
  - Expected: 2 entries buffered (`occupancy`=2) and `in_ready`=0.
  - After `hold` drops, 0x4 then 0x8 emerge on consecutive cycles with no loss or duplication.
- `flush` while FULL, with `in_valid`=1 and PC 0x100 in the same cycle.
  - Expected next cycle: `out_valid`=0, `out_instr`=0x00000013, `occupancy`=0, `in_ready`=1, `out_pc` unchanged.
  - 0x100 never appears at the output.
- `flush` and `hold` together while in ONE.
  - Expected: flush takes effect and `out_valid`=0.
- `rst_n`=0 pulsed while FULL.
  - Expected: `out_pc`=0 and `out_valid`=0.
  - `in_ready` is 0 during reset and 1 the cycle after release.
- Random `in_valid`/`out_ready`/`hold` for 10k cycles, checked against a reference FIFO.
  - Expected: outputs match in order.
  - Invariants hold: `occupancy` matches counted entries; `in_ready` is never 1 when `occupancy`=2.
